// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: walks every input vector of an n-input function,
// drives it to two implementations, waits a settle window, then compares
// their outputs. Counts mismatches and records the first failing vector.
module truth_table_sweeper #(
    parameter int MAX_N  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       num_in,
    input  logic             y_a,
    input  logic             y_b,
    output logic [MAX_N-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic             fail_flag,
    output logic [MAX_N:0]   mismatch_cnt,
    output logic [MAX_N-1:0] first_fail_vec
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [MAX_N-1:0] ONES = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       n_q, n_d;
    logic [MAX_N-1:0] k_q, k_d;
    logic [CW-1:0]    settle_q, settle_d;
    logic [MAX_N:0]   cnt_q, cnt_d;
    logic             fail_q, fail_d;
    logic [MAX_N-1:0] first_q, first_d;
    logic             cfg_q, cfg_d;

    logic             cfg_ok;
    logic             last_vec;
    logic             mismatch;
    logic [MAX_N-1:0] k_mask;

    // Accept only 1..MAX_N active inputs.
    assign cfg_ok   = (num_in != 3'd0) && ({29'd0, num_in} <= 32'(MAX_N));
    // All-ones in the low n bits marks the final vector of this sweep.
    assign k_mask   = ~(ONES << n_q);
    assign last_vec = (k_q == k_mask);
    assign mismatch = (y_a != y_b);

    // State register and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            fail_q   <= 1'b0;
            first_q  <= '0;
            cfg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            fail_q   <= fail_d;
            first_q  <= first_d;
            cfg_q    <= cfg_d;
        end
    end

    // Next-state logic: sequencing through apply / settle / check per vector.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start && cfg_ok) begin
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                state_d = abort ? S_IDLE : S_SETTLE;
            end
            S_SETTLE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (settle_q == '0) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_vec) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_APPLY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values: config latch, settle counter, vector index, results.
    always_comb begin
        n_d      = n_q;
        k_d      = k_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        first_d  = first_q;
        cfg_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        n_d     = num_in;
                        k_d     = '0;
                        cnt_d   = '0;
                        fail_d  = 1'b0;
                        first_d = '0;
                    end else begin
                        cfg_d = 1'b1;
                    end
                end
            end
            S_APPLY: begin
                settle_d = CW'(SETTLE - 1);
            end
            S_SETTLE: begin
                if (settle_q != '0) begin
                    settle_d = settle_q - CW'(1);
                end
            end
            S_CHECK: begin
                // An abort in the check cycle discards this vector's compare.
                if (!abort) begin
                    if (mismatch) begin
                        cnt_d = cnt_q + (MAX_N + 1)'(1);
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            first_d = k_q;
                        end
                    end
                    if (!last_vec) begin
                        k_d = k_q + MAX_N'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        vec  = '0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_APPLY, S_SETTLE, S_CHECK: begin
                vec  = k_q;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cfg_err        = cfg_q;
    assign fail_flag      = fail_q;
    assign mismatch_cnt   = cnt_q;
    assign first_fail_vec = first_q;

endmodule
